// File: rtl/avalon_pio_bidir.sv
// avalon_pio_bidir: Avalon-MM bidirectional PIO with atomic set/clear, synchronised inputs and edge-capture interrupt
module avalon_pio_bidir #(
  parameter int unsigned WIDTH = 8,
  parameter logic [31:0] OUT_RESET = 32'h0,
  parameter logic [31:0] DIR_RESET = 32'hFFFF_FFFF,
  parameter int unsigned EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d, cap_q, cap_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q, wdat, edg, clr, rsel;
  logic [31:0] rdata_q, rdata_d;
  logic wr, rd, unused_wdata;
  assign wr = chipselect & ~write_n;
  assign rd = chipselect & read;
  assign wdat = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  always_comb begin
    out_d = !wr ? out_q :
            address == 3'd0 ? wdat :
            address == 3'd4 ? out_q | wdat :
            address == 3'd5 ? out_q & ~wdat : out_q;
    dir_d = (wr && address == 3'd1) ? wdat : dir_q;
    mask_d = (wr && address == 3'd2) ? wdat : mask_q;
    edg = EDGE_TYPE == 0 ? sync2_q & ~prev_q :
          EDGE_TYPE == 1 ? ~sync2_q & prev_q : sync2_q ^ prev_q;
    clr = (wr && address == 3'd3) ? wdat : '0;
    // a new edge wins over a simultaneous write-1-to-clear
    cap_d = (cap_q & ~clr) | edg;
    rsel = address == 3'd0 ? sync2_q :
           address == 3'd1 ? dir_q :
           address == 3'd2 ? mask_q :
           address == 3'd3 ? cap_q : '0;
    rdata_d = rd ? 32'(rsel) : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= OUT_RESET[WIDTH-1:0];
      dir_q <= DIR_RESET[WIDTH-1:0];
      mask_q <= '0;
      cap_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q <= '0;
      rdata_q <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      mask_q <= mask_d;
      cap_q <= cap_d;
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      rdata_q <= rdata_d;
    end
  end
  assign readdata = rdata_q;
  assign pin_out = out_q;
  assign pin_oe = dir_q;
  assign irq = |(cap_q & mask_q);
endmodule

// File: doc/avalon_pio_bidir.md
# avalon_pio_bidir

Parametrised Avalon-MM slave PIO, the next-generation general-purpose port for the Qsys system. It replaces single-purpose one-bit output ports such as chip selects and strobes. Each of WIDTH pins has a per-bit direction, an output latch with atomic set and clear, a two-flop synchroniser on the input path, and edge capture with a maskable level interrupt. Reads are registered, giving one cycle of read latency.

## Interface
Parameters:
- WIDTH, 8: number of pins, 1..32.
- OUT_RESET, 0: reset value of the output latch (low WIDTH bits used).
- DIR_RESET, all ones: reset value of the direction register; 1 = output.
- EDGE_TYPE, 0: edge to capture; 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- read  in  1  active-high read strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- pin_in  in  WIDTH  asynchronous pin inputs.
- pin_out  out  WIDTH  output latch value.
- pin_oe  out  WIDTH  per-bit output enable (direction register).
- irq  out  1  level interrupt.

## Operation
- Register map (word addresses):
  - 0 DATA: read returns the synchronised input; write loads the output latch.
  - 1 DIR: read/write direction.
  - 2 IRQMASK: read/write interrupt mask.
  - 3 EDGECAP: read returns captured edges; write-1-to-clear.
  - 4 OUTSET: write-1 sets latch bits; reads 0.
  - 5 OUTCLR: write-1 clears latch bits; reads 0.
  - 6, 7: writes ignored; reads 0.
- Write event: chipselect && !write_n. Only writedata[WIDTH-1:0] is used.
- Read event: chipselect && read. Read bits above WIDTH are 0.
- Input path:
  - sync1 <= pin_in; sync2 <= sync1; prev <= sync2.
  - DATA reads sync2 for all bits, regardless of direction.
- Edge detect, per bit:
  - rising: sync2 & ~prev
  - falling: ~sync2 & prev
  - any: sync2 ^ prev
- Edge capture:
  - edgecap <= (edgecap & ~clr) | edge, where clr = writedata when EDGECAP is written, else 0.
  - If an edge and a clear hit the same bit in the same cycle, the set wins.
- irq = |(edgecap & irqmask), a combinational function of registers only.
- Simultaneous write and read in one cycle:
  - both are performed;
  - readdata returns the pre-write register value.
- Reset values:
  - pin_out = OUT_RESET
  - pin_oe = DIR_RESET
  - irqmask = 0
  - edgecap = 0
  - sync1, sync2, prev = 0
  - readdata = 0
  - irq = 0
- Reset asserted mid-operation: all of the above take their reset values at the next edge. A write in that cycle is discarded.
- Synchroniser note: prev resets to 0, so a pin already high at reset release produces one rising edge about 2 cycles later. This is accepted behaviour; software clears EDGECAP after init.

## Timing
- Writes take effect at the clk edge where the write event is sampled. pin_out and pin_oe change in the following cycle.
- Read latency is 1:
  - read event sampled at edge k, readdata valid after edge k;
  - readdata holds until the next read event;
  - readdata is 0 after reset.
- Input to capture, for pin_in changing before edge k:
  - sync1 updates at k;
  - sync2 at k+1;
  - edgecap bit set at k+2;
  - irq high after k+2 if the bit is masked in.
- DATA read issued at edge k+1 (sync2 loads at k+1) returns the old value; issued at k+2 returns the new value.
- A pulse shorter than one clk period may be missed. This is not required to be detected.
- No wait states. The slave accepts every cycle.

## Test plan
- Reset with OUT_RESET=8'hA5, DIR_RESET=8'hFF, then write DATA=8'h3C -> pin_out=8'hA5 after reset, 8'h3C one cycle after the write; read DATA with pin_in=8'h81 returns 32'h81.
- Atomic set/clear: pin_out=8'h0F; write OUTSET=8'hF0 -> 8'hFF; write OUTCLR=8'h81 -> 8'h7E; reads of addresses 4 and 5 return 0.
- Edge capture, EDGE_TYPE=0, IRQMASK=8'h02: pin_in bit1 0->1 -> EDGECAP=8'h02 and irq=1 exactly 3 edges later; bit1 1->0 -> no change; write EDGECAP=8'h02 -> irq=0 next cycle.
- Clear/set collision: time an EDGECAP write of 8'h01 to the cycle a bit0 edge is detected -> bit0 stays 1 and irq stays asserted.
- EDGE_TYPE=2, WIDTH=32: toggle pin_in[31] twice -> bit31 set after the first toggle; readdata[31] correct; unmapped address 7 reads 0.
- Reset mid-operation: assert reset in the same cycle as a DATA write of 8'hFF -> pin_out=OUT_RESET, edgecap=0, irq=0, readdata=0; the write is lost.
